zmips_wb_unit: RTL and testbench
================================

// Module: zmips_wb_unit
// PURPOSE
// - Writeback unit: sole driver of the zmips_regfile write port (wr, wr_addr, wr_data).
// - Merges single-cycle ALU results with variable-latency memory-load results; buffers loads in a small FIFO.
// - Holds a pending-write scoreboard, so the issue stage can detect RAW hazards on the two regfile read addresses.
// PARAMETERS
// - DEPTH  4  load FIFO entries; power of 2, >= 2
// - CW     3  width of fifo_cnt; equals log2(DEPTH)+1
// PORTS
// - clk        in   1   clock; all state updates on rising edge
// - rst_n      in   1   asynchronous, active-low reset
// - alu_valid  in   1   ALU result valid this cycle; never back-pressured
// - alu_addr   in   5   ALU destination register
// - alu_data   in   32  ALU result
// - mem_valid  in   1   load result offered
// - mem_ready  out  1   load result accepted when mem_valid & mem_ready
// - mem_addr   in   5   load destination register
// - mem_data   in   32  load data
// - iss_valid  in   1   issue stage reserves a destination this cycle
// - iss_addr   in   5   reserved destination register
// - rd_addr_0  in   5   regfile read address, port 0 (mirrors addr_0)
// - rd_addr_1  in   5   regfile read address, port 1 (mirrors addr_1)
// - busy_0     out  1   rd_addr_0 has a pending write
// - busy_1     out  1   rd_addr_1 has a pending write
// - wr         out  1   regfile write enable
// - wr_addr    out  5   regfile write address
// - wr_data    out  32  regfile write data
// - bad_addr   out  1   one-cycle pulse: a result targeting r30/r31 was dropped
// - fifo_cnt   out  CW  load FIFO occupancy, 0..DEPTH
// BEHAVIOUR
// Reset (async, rst_n=0):
// - wr=0, wr_addr=0, wr_data=0, bad_addr=0.
// - FIFO empty, fifo_cnt=0, scoreboard cleared; mem_ready=1 while in reset.
// Write selection (evaluated each cycle, priority order):
// - 1) alu_valid: write the ALU result.
// - 2) FIFO non-empty: pop the head and write it.
// - 3) mem_valid & FIFO empty: write the load directly (bypasses the FIFO).
// - 4) Otherwise no write.
// - The selected result is registered: wr/wr_addr/wr_data are valid the cycle after input (latency 1).
// - The regfile commits the write on the following edge.
// - An accepted load not chosen this cycle is pushed to the FIFO tail.
// Handshake and FIFO:
// - mem_ready = !full, combinational from occupancy only.
// - When full, no push occurs, even if a pop happens in the same cycle.
// - Simultaneous push and pop: occupancy unchanged; order preserved.
// - Pointers wrap modulo DEPTH.
// - fifo_cnt is registered, and returns to 0 only when the FIFO is truly empty.
// Protected addresses:
// - A result with &addr[4:1] (r30, r31) is consumed but never written; wr stays 0.
// - bad_addr pulses 1 on the cycle wr would have been asserted.
// - iss_addr r30/r31 is ignored by the scoreboard.
// Scoreboard:
// - 30-bit pend vector.
// - Set: iss_valid sets pend[iss_addr].
// - Clear: the cycle wr=1 clears pend[wr_addr].
// - Same bit set and cleared in one cycle: set wins.
// - busy_x = pend[rd_addr_x], combinational; 0 for addresses 30/31.
// Reset mid-operation: FIFO contents and pending writes are discarded, with no partial write.
// CONFIGURATION
// - ZMIPS_WB_BYPASS_EN defined: adds outputs fwd_hit_0/1 (1) and fwd_data_0/1 (32).
//   - fwd_hit_x = wr & (wr_addr == rd_addr_x); fwd_data_x = wr_data.
//   - busy_x is forced to 0 when fwd_hit_x=1, so the issue stage may consume the forwarded value.
// - Not defined: no fwd ports; busy_x = pend[rd_addr_x] unmodified.
//   - The issue stage stalls one extra cycle until the regfile holds the value.
// TESTING
// - ALU only: alu_valid=1, addr=5, data=0xDEADBEEF.
//   -> next cycle wr=1, wr_addr=5, wr_data=0xDEADBEEF; regfile r5 updated one edge later.
// - Collision: alu(3,0x11) and mem(4,0x22) in the same cycle.
//   -> cycle+1 writes r3=0x11, cycle+2 writes r4=0x22; fifo_cnt goes 1 then 0.
// - Fill: hold alu_valid=1 and offer 5 loads.
//   -> 4 accepted; mem_ready=0 after the 4th.
//   -> drop alu_valid: four writes drain in push order, then mem_ready=1.
// - Protected address: alu_valid with addr=30 -> wr stays 0, bad_addr=1 for one cycle, pend unchanged.
// - Scoreboard: iss(7) -> busy_0=1 with rd_addr_0=7.
//   - A load to r7 is written -> busy_0=0 the cycle after wr.
//   - iss(7) again on the same clearing cycle -> busy_0 stays 1.
// - Reset mid-drain: FIFO holding 3 entries, pulse rst_n=0.
//   -> wr=0 immediately, fifo_cnt=0, mem_ready=1, busy_0/busy_1=0.
//   -> no stale write after release.

Source files
------------

// File: rtl/zmips_wb_unit.sv
// zmips_wb_unit: writeback stage for the zmips core.
//   Only driver of the regfile write port. Each cycle it picks one result,
//   in priority order: ALU result, oldest buffered load, then a load taken
//   straight from the memory port when the buffer is empty. Loads that are
//   accepted but not picked wait in a DEPTH-entry FIFO. A pending-write
//   scoreboard lets the issue stage detect RAW hazards on both read ports.
//   Results for r30/r31 are consumed and dropped, and bad_addr pulses once.
//
// Build option: define ZMIPS_WB_BYPASS_EN to add the fwd_hit_x/fwd_data_x
//   forwarding outputs; busy_x is then masked by fwd_hit_x.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   alu_valid/alu_addr/alu_data     single-cycle ALU result (never stalled)
//   mem_valid/mem_ready/mem_addr/mem_data  load result handshake
//   iss_valid/iss_addr              issue-stage destination reservation
//   rd_addr_0/1, busy_0/1           scoreboard lookup for regfile reads
//   wr/wr_addr/wr_data              registered regfile write port
//   bad_addr                        pulse: a result to r30/r31 was dropped
//   fifo_cnt                        registered load FIFO occupancy
//   fwd_hit_0/1, fwd_data_0/1       forwarding (ZMIPS_WB_BYPASS_EN only)
module zmips_wb_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [4:0]    alu_addr,
    input  logic [31:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_addr,
    input  logic [31:0]   mem_data,
    input  logic          iss_valid,
    input  logic [4:0]    iss_addr,
    input  logic [4:0]    rd_addr_0,
    input  logic [4:0]    rd_addr_1,
    output logic          busy_0,
    output logic          busy_1,
    output logic          wr,
    output logic [4:0]    wr_addr,
    output logic [31:0]   wr_data,
    output logic          bad_addr,
    output logic [CW-1:0] fifo_cnt
`ifdef ZMIPS_WB_BYPASS_EN
    ,
    output logic          fwd_hit_0,
    output logic          fwd_hit_1,
    output logic [31:0]   fwd_data_0,
    output logic [31:0]   fwd_data_1
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    wb_entry_t     fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [29:0]   pend_q, pend_d;
    logic          wr_q, wr_d;
    logic          bad_q, bad_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic      full, empty, accept, push, pop, sel_valid, sel_prot;
    wb_entry_t sel;

    // Result selection, FIFO bookkeeping and scoreboard next state
    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        empty     = (cnt_q == '0);
        accept    = mem_valid & ~full;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel       = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel       = '{addr: alu_addr, data: alu_data};
        end else if (!empty) begin
            sel_valid = 1'b1;
            pop       = 1'b1;
            sel       = fifo_q[rd_ptr_q];
        end else if (mem_valid) begin
            sel_valid = 1'b1;
            sel       = '{addr: mem_addr, data: mem_data};
        end
        // A load is buffered whenever something else owns the write slot
        push      = accept & (alu_valid | ~empty);
        sel_prot  = &sel.addr[4:1];

        wr_d      = sel_valid & ~sel_prot;
        bad_d     = sel_valid & sel_prot;
        wr_addr_d = wr_d ? sel.addr : wr_addr_q;
        wr_data_d = wr_d ? sel.data : wr_data_q;

        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);

        // Clear on the write cycle first so a same-cycle reservation wins
        pend_d = pend_q;
        if (wr_q && !(&wr_addr_q[4:1])) begin
            pend_d[wr_addr_q] = 1'b0;
        end
        if (iss_valid && !(&iss_addr[4:1])) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            wr_q      <= 1'b0;
            bad_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            wr_q      <= wr_d;
            bad_q     <= bad_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO storage; contents are only meaningful under the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: mem_addr, data: mem_data};
        end
    end

    // Scoreboard lookup; r30/r31 are never tracked
    logic pend_0, pend_1;
    always_comb begin
        pend_0 = !(&rd_addr_0[4:1]) && pend_q[rd_addr_0];
        pend_1 = !(&rd_addr_1[4:1]) && pend_q[rd_addr_1];
    end

`ifdef ZMIPS_WB_BYPASS_EN
    // Forward the in-flight write so the issue stage need not wait for it
    assign fwd_hit_0  = wr_q & (wr_addr_q == rd_addr_0);
    assign fwd_hit_1  = wr_q & (wr_addr_q == rd_addr_1);
    assign fwd_data_0 = wr_data_q;
    assign fwd_data_1 = wr_data_q;
    assign busy_0     = pend_0 & ~fwd_hit_0;
    assign busy_1     = pend_1 & ~fwd_hit_1;
`else
    assign busy_0     = pend_0;
    assign busy_1     = pend_1;
`endif

    assign mem_ready = ~full;
    assign wr        = wr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign bad_addr  = bad_q;
    assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_zmips_wb_unit.sv
// Self-checking bench for zmips_wb_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_zmips_wb_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid, iss_valid;
    logic [4:0]    alu_addr, mem_addr, iss_addr, rd_addr_0, rd_addr_1;
    logic [31:0]   alu_data, mem_data;
    logic          mem_ready, busy_0, busy_1, wr, bad_addr;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [CW-1:0] fifo_cnt;
`ifdef ZMIPS_WB_BYPASS_EN
    logic          fwd_hit_0, fwd_hit_1;
    logic [31:0]   fwd_data_0, fwd_data_1;
`endif

    always #5 clk = ~clk;

    zmips_wb_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .busy_0(busy_0), .busy_1(busy_1),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .bad_addr(bad_addr), .fifo_cnt(fifo_cnt)
`ifdef ZMIPS_WB_BYPASS_EN
        , .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
        .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1)
`endif
    );

    // Reference model: a queue of pending loads, the expected write port,
    // and the set of registers with outstanding writes.
    typedef struct {
        int          addr;
        logic [31:0] data;
    } res_t;

    res_t        mq[$];
    bit          m_wr, m_bad;
    int          m_addr;
    logic [31:0] m_data;
    bit          m_pend[32];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wr = 0; m_bad = 0; m_addr = 0; m_data = '0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    function automatic bit exp_busy(input int ra);
        bit b;
        b = (ra < 30) && m_pend[ra];
`ifdef ZMIPS_WB_BYPASS_EN
        if (m_wr && m_addr == ra) b = 0;
`endif
        return b;
    endfunction

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = '0; alu_data = '0;
        mem_valid = 0; mem_addr = '0; mem_data = '0;
        iss_valid = 0; iss_addr = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic step();
        res_t sel;
        bit   selv, ready;
        #1;
        ready = (mq.size() < DEPTH);
        chk("mem_ready", 32'(mem_ready), 32'(ready));
        chk("busy_0", 32'(busy_0), 32'(exp_busy(int'(rd_addr_0))));
        chk("busy_1", 32'(busy_1), 32'(exp_busy(int'(rd_addr_1))));
`ifdef ZMIPS_WB_BYPASS_EN
        chk("fwd_hit_0", 32'(fwd_hit_0), 32'(m_wr && m_addr == int'(rd_addr_0)));
        if (m_wr) chk("fwd_data_0", fwd_data_0, m_data);
`endif
        selv = 1;
        if (alu_valid) begin
            sel = '{int'(alu_addr), alu_data};
            if (mem_valid && ready) mq.push_back('{int'(mem_addr), mem_data});
        end else if (mq.size() != 0) begin
            sel = mq.pop_front();
            if (mem_valid && ready) mq.push_back('{int'(mem_addr), mem_data});
        end else if (mem_valid) begin
            sel = '{int'(mem_addr), mem_data};
        end else begin
            selv = 0;
            sel  = '{0, '0};
        end
        if (m_wr) m_pend[m_addr] = 0;
        if (iss_valid && iss_addr < 30) m_pend[iss_addr] = 1;
        m_wr  = selv && sel.addr < 30;
        m_bad = selv && sel.addr >= 30;
        if (m_wr) begin
            m_addr = sel.addr;
            m_data = sel.data;
        end
        @(posedge clk);
        #1;
        chk("wr", 32'(wr), 32'(m_wr));
        chk("bad_addr", 32'(bad_addr), 32'(m_bad));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        if (m_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", wr_data, m_data);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        rd_addr_0 = 5'd7;
        rd_addr_1 = 5'd0;
        model_reset();
        #2;
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_bad", 32'(bad_addr), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // ALU only
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_wr", 32'(wr), 32'd1);
        chk("alu_data", wr_data, 32'hDEADBEEF);
        idle_inputs();
        step();

        // Collision: ALU wins, load goes through the FIFO
        alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h11;
        mem_valid = 1; mem_addr = 5'd4; mem_data = 32'h22;
        step();
        chk("col_cnt1", 32'(fifo_cnt), 32'd1);
        idle_inputs();
        step();
        chk("col_addr2", 32'(wr_addr), 32'd4);
        chk("col_cnt0", 32'(fifo_cnt), 32'd0);

        // Fill: ALU holds the slot while five loads are offered
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1; alu_addr = 5'(10 + i); alu_data = 32'(100 + i);
            mem_valid = 1; mem_addr = 5'(20 + i); mem_data = 32'(200 + i);
            step();
        end
        #1;
        chk("fill_ready", 32'(mem_ready), 32'd0);
        chk("fill_cnt", 32'(fifo_cnt), 32'd4);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_order", wr_data, 32'(200 + i));
        end
        #1;
        chk("drain_ready", 32'(mem_ready), 32'd1);

        // Protected address
        alu_valid = 1; alu_addr = 5'd30; alu_data = 32'h55;
        step();
        chk("prot_wr", 32'(wr), 32'd0);
        chk("prot_bad", 32'(bad_addr), 32'd1);
        idle_inputs();
        step();
        chk("prot_bad_clr", 32'(bad_addr), 32'd0);

        // Scoreboard: reserve r7, write it, then reserve on the clearing cycle
        iss_valid = 1; iss_addr = 5'd7;
        step();
        idle_inputs();
        #1; chk("sb_busy", 32'(busy_0), 32'd1);
        mem_valid = 1; mem_addr = 5'd7; mem_data = 32'h77;
        step();
        idle_inputs();
        step();
        chk("sb_clear", 32'(busy_0), 32'd0);
        iss_valid = 1; iss_addr = 5'd7;
        step();
        idle_inputs();
        mem_valid = 1; mem_addr = 5'd7; mem_data = 32'h78;
        step();
        idle_inputs();
        iss_valid = 1; iss_addr = 5'd7;
        step();
        idle_inputs();
        step();
        chk("sb_set_wins", 32'(busy_0), 32'd1);

        // Reset mid-drain with three buffered loads
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_addr = 5'(1 + i); alu_data = 32'(i);
            mem_valid = 1; mem_addr = 5'(8 + i); mem_data = 32'(300 + i);
            iss_valid = 1; iss_addr = 5'(8 + i);
            step();
        end
        idle_inputs();
        rd_addr_0 = 5'd8; rd_addr_1 = 5'd9;
        rst_n = 0;
        model_reset();
        #1;
        chk("mrst_wr", 32'(wr), 32'd0);
        chk("mrst_cnt", 32'(fifo_cnt), 32'd0);
        chk("mrst_ready", 32'(mem_ready), 32'd1);
        chk("mrst_busy0", 32'(busy_0), 32'd0);
        chk("mrst_busy1", 32'(busy_1), 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) step();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            alu_valid = ($urandom_range(9) < 4);
            alu_addr  = 5'($urandom_range(31));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(1) == 1);
            mem_addr  = 5'($urandom_range(31));
            mem_data  = $urandom;
            iss_valid = ($urandom_range(2) == 0);
            iss_addr  = 5'($urandom_range(31));
            rd_addr_0 = 5'($urandom_range(31));
            rd_addr_1 = 5'($urandom_range(31));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
